// File: rtl/cordic_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cordic_arbiter_pkg
// Purpose : shared constants for the CORDIC request arbiter. Defines the
//           operation word layout (func bit plus x/y/z fields) and a helper
//           that sizes requester tags.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package cordic_arbiter_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int TOTAL_WIDTH = 3 * DATA_WIDTH + 1;    // 49
    localparam int FUNC_BIT    = 3 * DATA_WIDTH;        // bit 48
    localparam int X_LSB       = 2 * DATA_WIDTH;        // [47:32]
    localparam int Y_LSB       = DATA_WIDTH;            // [31:16]
    localparam int Z_LSB       = 0;                     // [15:0]

    // Tag width for n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cordic_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cordic_rr_arbiter
// Purpose : purely combinational round-robin pick. Searches i_req starting
//           at i_ptr and wrapping, and returns the first hit.
// Ports   : i_req  - request vector (already qualified by the caller)
//           i_ptr  - index that has highest priority this cycle
//           o_gnt  - one-hot grant, all zero when nothing requests
//           o_idx  - binary index of the grant (0 when o_any is low)
//           o_any  - a grant was made
// ---------------------------------------------------------------------------
module cordic_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [ID_WIDTH-1:0] i_ptr,
    output logic [NUM_REQ-1:0]  o_gnt,
    output logic [ID_WIDTH-1:0] o_idx,
    output logic                o_any
);

    always_comb begin
        int j;
        j     = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Rotate the search origin to i_ptr; i_ptr is always < NUM_REQ,
            // so one subtraction is enough to wrap.
            j = int'(i_ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!o_any && i_req[j]) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = ID_WIDTH'(j);
            end
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// ---------------------------------------------------------------------------
// cordic_arbiter
// Purpose : shares one fixed-latency CORDIC core between NUM_REQ requesters.
//           Round-robin grant among requesters that are valid and below their
//           in-flight limit, one issue per cycle, requester tags carried in a
//           delay line matched to the core so results return to their owner.
// Ports   : i_clk, i_rst             - clock, async active-high reset
//           i_req_vld / i_req_data    - per-requester op (slice k = req k)
//           o_req_rdy                 - one-hot grant (transfer on vld&rdy)
//           o_core_vld / o_core_data  - registered issue to the core
//           i_core_vld / i_core_data  - core result
//           o_rsp_vld / o_rsp_data    - one-hot registered response
//           o_err                     - sticky tag/result mismatch
// ---------------------------------------------------------------------------
module cordic_arbiter
    import cordic_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int TOTAL_WIDTH     = cordic_arbiter_pkg::TOTAL_WIDTH,
    parameter int CORE_LATENCY    = 5,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ID_WIDTH        = id_width(NUM_REQ)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_vld,
    input  logic [NUM_REQ*TOTAL_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]             o_req_rdy,
    output logic                           o_core_vld,
    output logic [TOTAL_WIDTH-1:0]         o_core_data,
    input  logic                           i_core_vld,
    input  logic [TOTAL_WIDTH-1:0]         i_core_data,
    output logic [NUM_REQ-1:0]             o_rsp_vld,
    output logic [TOTAL_WIDTH-1:0]         o_rsp_data,
    output logic                           o_err
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [NUM_REQ-1:0][CW-1:0]         r_cnt;
    logic [ID_WIDTH-1:0]                r_ptr;
    // Stage 0 is written at accept; stage CORE_LATENCY lines up with
    // i_core_vld for the op that was presented on o_core_vld.
    logic [CORE_LATENCY:0]              r_tag_vld;
    logic [CORE_LATENCY:0][ID_WIDTH-1:0] r_tag_id;

    logic [NUM_REQ-1:0]  w_elig;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [ID_WIDTH-1:0] w_idx;
    logic                w_acc;
    logic                w_head_vld;
    logic [ID_WIDTH-1:0] w_head_id;

    // A count at the limit blocks even if a release lands this cycle; the
    // freed credit is only visible after the counter updates.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++)
            w_elig[k] = i_req_vld[k] && (r_cnt[k] < CW'(MAX_OUTSTANDING));
    end

    cordic_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .i_req (w_elig),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_acc)
    );

    assign o_req_rdy  = w_gnt;
    assign w_head_vld = r_tag_vld[CORE_LATENCY];
    assign w_head_id  = r_tag_id[CORE_LATENCY];

    // Issue stage, pointer and tag delay line.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr       <= '0;
            o_core_vld  <= 1'b0;
            o_core_data <= '0;
            r_tag_vld   <= '0;
            r_tag_id    <= '0;
        end else begin
            o_core_vld <= w_acc;
            r_tag_vld  <= {r_tag_vld[CORE_LATENCY-1:0], w_acc};
            r_tag_id   <= {r_tag_id[CORE_LATENCY-1:0], w_idx};
            if (w_acc) begin
                o_core_data <= i_req_data[w_idx*TOTAL_WIDTH +: TOTAL_WIDTH];
                r_ptr       <= (w_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

    // Credits: +1 on accept, -1 when the valid head retires (matched result
    // or not, so a lost result cannot wedge the requester).
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
        logic w_inc, w_dec;
        assign w_inc = w_acc && (w_idx == ID_WIDTH'(k));
        assign w_dec = w_head_vld && (w_head_id == ID_WIDTH'(k));

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)               r_cnt[k] <= '0;
            else if (w_inc && !w_dec) r_cnt[k] <= r_cnt[k] + 1'b1;
            else if (w_dec && !w_inc) r_cnt[k] <= r_cnt[k] - 1'b1;
        end
    end

    // Response routing and mismatch detection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rsp_vld  <= '0;
            o_rsp_data <= '0;
            o_err      <= 1'b0;
        end else begin
            o_rsp_vld <= '0;
            if (i_core_vld && w_head_vld) begin
                o_rsp_vld[w_head_id] <= 1'b1;
                o_rsp_data           <= i_core_data;
            end else if (i_core_vld != w_head_vld) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
module tb_cordic_arbiter;

    localparam int N  = 4;
    localparam int W  = 49;
    localparam int L  = 5;
    localparam logic [W-1:0] MASK = 49'h1_0000_FFFF_0000;   // model core: op ^ MASK

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_vld;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_rdy;
    logic             core_vld_o;
    logic [W-1:0]     core_data_o;
    logic             core_vld_i;
    logic [W-1:0]     core_data_i;
    logic [N-1:0]     rsp_vld;
    logic [W-1:0]     rsp_data;
    logic             err;
    logic             inj;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] d [N];

    always #5 clk = ~clk;

    cordic_arbiter #(
        .NUM_REQ         (N),
        .TOTAL_WIDTH     (W),
        .CORE_LATENCY    (L),
        .MAX_OUTSTANDING (2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_vld   (req_vld),
        .i_req_data  (req_data),
        .o_req_rdy   (req_rdy),
        .o_core_vld  (core_vld_o),
        .o_core_data (core_data_o),
        .i_core_vld  (core_vld_i),
        .i_core_data (core_data_i),
        .o_rsp_vld   (rsp_vld),
        .o_rsp_data  (rsp_data),
        .o_err       (err)
    );

    // Model CORDIC core: fixed L-cycle delay, result = op ^ MASK.
    logic [L-1:0]        cv;
    logic [L-1:0][W-1:0] cd;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cv <= '0;
            cd <= '0;
        end else begin
            cv <= {cv[L-2:0], core_vld_o};
            cd <= {cd[L-2:0], core_data_o};
        end
    end
    assign core_vld_i  = cv[L-1] | inj;
    assign core_data_i = inj ? 49'h0_DEAD_BEEF_0001 : (cd[L-1] ^ MASK);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        d[0] = 49'h0_0001_0002_0003;
        d[1] = 49'h1_1111_2222_3333;
        d[2] = 49'h1_4000_0000_2000;
        d[3] = 49'h0_7FFF_8000_FFFF;
        req_data = {d[3], d[2], d[1], d[0]};
        req_vld  = '0;
        inj      = 1'b0;
        rst      = 1'b1;

        // ---- reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_core_vld",  64'(core_vld_o),  64'h0);
        chk("rst_core_data", 64'(core_data_o), 64'h0);
        chk("rst_rsp_vld",   64'(rsp_vld),     64'h0);
        chk("rst_rsp_data",  64'(rsp_data),    64'h0);
        chk("rst_err",       64'(err),         64'h0);
        rst = 1'b0;
        tick();

        // ---- fairness: all four valid, grants 0,1,2,3,0,...
        req_vld = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("fair_rdy_c%0d", i), 64'(req_rdy), 64'(4'b0001 << (i % 4)));
            if (i > 0) begin
                chk($sformatf("fair_cvld_c%0d", i), 64'(core_vld_o), 64'h1);
                chk($sformatf("fair_cdat_c%0d", i), 64'(core_data_o), 64'(d[(i-1) % 4]));
            end
            if (i == 7) begin
                chk("fair_rsp_vld_c7",  64'(rsp_vld),  64'h1);
                chk("fair_rsp_data_c7", 64'(rsp_data), 64'h1_0001_FFFD_0003);
            end
            tick();
        end
        req_vld = '0;
        repeat (15) tick();

        // ---- single request from requester 2
        req_vld = 4'b0100;
        #1;
        chk("single_rdy", 64'(req_rdy), 64'h4);
        tick();
        req_vld = '0;
        #1;
        chk("single_cvld",  64'(core_vld_o),  64'h1);
        chk("single_cdata", 64'(core_data_o), 64'h1_4000_0000_2000);
        repeat (5) tick();
        chk("single_rsp_early", 64'(rsp_vld), 64'h0);
        tick();
        chk("single_rsp_vld",  64'(rsp_vld),  64'h4);
        chk("single_rsp_data", 64'(rsp_data), 64'h0_4000_FFFF_2000);
        tick();
        chk("single_rsp_clr",  64'(rsp_vld),  64'h0);
        chk("single_rsp_hold", 64'(rsp_data), 64'h0_4000_FFFF_2000);
        repeat (5) tick();

        // ---- requester 1: accept in the same cycle its earlier op retires
        req_vld = 4'b0010;
        #1;
        chk("sim_rdy_c0", 64'(req_rdy), 64'h2);
        tick();
        req_vld = '0;
        repeat (5) tick();
        req_vld = 4'b0010;
        #1;
        chk("sim_rdy_c6", 64'(req_rdy), 64'h2);
        tick();
        #1;
        chk("sim_rdy_c7", 64'(req_rdy), 64'h2);
        tick();
        #1;
        chk("sim_rdy_c8", 64'(req_rdy), 64'h0);
        req_vld = '0;
        repeat (15) tick();

        // ---- credit limit on requester 0: accepts at 0,1,7,8,14
        req_vld = 4'b0001;
        for (int i = 0; i < 15; i++) begin
            #1;
            chk($sformatf("credit_rdy_c%0d", i), 64'(req_rdy),
                (i == 0 || i == 1 || i == 7 || i == 8 || i == 14) ? 64'h1 : 64'h0);
            tick();
        end
        req_vld = '0;
        repeat (15) tick();

        // ---- mismatch: result with an empty tag pipe
        chk("err_before_inj", 64'(err), 64'h0);
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("err_set",      64'(err),     64'h1);
        chk("err_no_rsp",   64'(rsp_vld), 64'h0);
        repeat (3) tick();
        chk("err_sticky",   64'(err),     64'h1);

        // ---- reset with three ops in flight (grants 1,2,1 leave ptr at 2)
        req_vld = 4'b0110;
        repeat (3) tick();
        req_vld = '0;
        chk("pre_rst_cvld", 64'(core_vld_o), 64'h1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_cvld",  64'(core_vld_o),  64'h0);
        chk("mid_rst_cdata", 64'(core_data_o), 64'h0);
        chk("mid_rst_err",   64'(err),         64'h0);
        chk("mid_rst_rsp",   64'(rsp_vld),     64'h0);
        #1 rst = 1'b0;
        tick();
        req_vld = 4'b1111;
        #1;
        chk("post_rst_ptr0", 64'(req_rdy), 64'h1);
        tick();
        req_vld = 4'b0010;
        #1;
        chk("post_rst_cnt1_clear", 64'(req_rdy), 64'h2);
        tick();
        req_vld = '0;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
